lcd_bus_scheduler: RTL and testbench
====================================

// Module: lcd_bus_scheduler
// PURPOSE
//  Owns the single LCD serial transceiver (lcd_tcvr) and shares it between two requesters.
//  After reset it plays a fixed power-on init table of register writes to the LCD.
//  It then arbitrates round-robin between req0 (host CPU) and req1 (refresh engine).
//  Each granted request is sequenced through one transceiver write or read.
//  A completion pulse is returned to the requester, with read data or an error flag.
// PARAMETERS
//  INIT_LEN        8     number of entries in the power-on init table (0 = skip init)
//  TIMEOUT_CYCLES  4096  i_clock cycles allowed from begin-accept to done before abort
// PORTS
//  i_clock        in   1   system clock (same clock as lcd_tcvr i_clock)
//  i_resetN       in   1   asynchronous, active-low reset
//  i_req0/i_req1  in   1   level request; hold until matching o_ack pulse
//  i_rd0/i_rd1    in   1   1 = read, 0 = write; sampled at grant
//  i_addr0/i_addr1 in  7   LCD register address; sampled at grant
//  i_wdata0/i_wdata1 in 8  write data; sampled at grant
//  o_ack0/o_ack1  out  1   one-cycle completion pulse for that requester
//  o_rdata        out  8   read data; valid in the o_ack cycle, held until next completion
//  o_error        out  1   valid with o_ack: 1 = transfer timed out
//  o_initDone     out  1   high once the init table has completed; stays high until reset
//  o_txBegin      out  1   to lcd_tcvr i_txBegin
//  o_rxBegin      out  1   to lcd_tcvr i_rxBegin
//  o_address      out  7   to lcd_tcvr i_address; held stable from issue until completion
//  o_txData       out  8   to lcd_tcvr i_txData; held stable from issue until completion
//  i_txBusy/i_rxBusy in 1  from lcd_tcvr
//  i_txDone/i_rxDone in 1  from lcd_tcvr
//  i_rxData       in   8   from lcd_tcvr o_rxData
// BEHAVIOUR
//  Reset (async assert, sync release): state S_INIT; all outputs 0; init index 0; rr pointer = req0.
//  States and transitions:
//    S_INIT      if index == INIT_LEN: set o_initDone, go S_IDLE.
//                else: load {addr, data} = INIT_TABLE[index] as a write; go S_ISSUE.
//    S_IDLE      grant only if o_initDone. Single request: grant it.
//                Both pending: grant the port not served last, then flip the pointer.
//                At grant: latch rd, addr and wdata into o_address/o_txData; go S_ISSUE.
//    S_ISSUE     drive o_txBegin (write) or o_rxBegin (read), never both.
//                Hold until the matching busy = 1, then drop begin, clear timer, go S_WAIT_DONE.
//    S_WAIT_DONE wait for the matching done = 1; for a read, capture i_rxData into o_rdata.
//                Then go S_WAIT_IDLE.
//    S_WAIT_IDLE wait for busy = 0 and done = 0, so the transceiver can take the next job.
//                Then go S_COMPLETE.
//    S_COMPLETE  init op: index++, go S_INIT (no ack).
//                Request op: pulse the granted o_ack for 1 cycle with o_error = 0; go S_IDLE.
//  Timeout: a 16-bit timer runs in S_ISSUE, S_WAIT_DONE and S_WAIT_IDLE.
//    If it reaches TIMEOUT_CYCLES: drop begin, set o_error = 1, go S_COMPLETE.
//    o_rdata is unchanged on a read timeout. An init-op timeout still advances the index.
//  Latency: the grant cycle is the cycle the request is seen in S_IDLE; begin asserts 1 cycle later.
//  An ack never occurs in the same cycle as a new grant.
//    A requester may re-raise req in the cycle after its ack.
//  Requests arriving during init are held pending; they are not lost and not acked early.
//  A request dropped before its ack is illegal; behaviour is unspecified, and the bench must not do it.
//  Reset mid-transfer: begins drop immediately. lcd_tcvr has no reset, so after release the
//    scheduler does not issue the first S_INIT entry until busy = 0.
// STRUCTURE
//  Package lcd_pkg: state encodings; INIT_TABLE as a constant function returning {addr[6:0], data[7:0]}
//    by index; address constants shared with lcd_tcvr users.
//  Sub-module lcd_rr_arbiter: 2-port round-robin grant with a pointer register.
//  Everything else is a single FSM plus the timer.
// TESTING
//  Use a behavioural lcd_tcvr model with configurable latency.
//  1 Reset, INIT_LEN=8: exactly 8 writes in table order (e.g. entry0 addr 7'h01 data 8'h80),
//    no acks during init, then o_initDone = 1.
//  2 After init, req0 write addr 7'h12 data 8'hA5: o_txBegin held until txBusy, model sees 12/A5,
//    one o_ack0 with o_error = 0.
//  3 req1 read addr 7'h20, model returns 8'h3C: o_rxBegin only, o_rdata = 8'h3C at o_ack1, o_error = 0.
//  4 req0 and req1 held continuously, 6 transactions: grants alternate 0,1,0,1,...; no back-to-back
//    grants without S_WAIT_IDLE.
//  5 Model never asserts done, TIMEOUT_CYCLES=64: ack with o_error = 1 at 64 cycles after accept;
//    the next request proceeds normally.
//  6 Assert i_resetN low mid-read: outputs 0 asynchronously; after release, init replays from entry 0
//    once busy = 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions: FSM states, register map
// and the power-on init table.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_WAIT_IDLE,
    S_COMPLETE
  } state_e;

  localparam logic [6:0] LCD_REG_POWER    = 7'h01;
  localparam logic [6:0] LCD_REG_DISP     = 7'h02;
  localparam logic [6:0] LCD_REG_CONTRAST = 7'h03;
  localparam logic [6:0] LCD_REG_BIAS     = 7'h04;
  localparam logic [6:0] LCD_REG_SCROLL   = 7'h05;
  localparam logic [6:0] LCD_REG_CLEAR    = 7'h06;
  localparam logic [6:0] LCD_REG_MODE     = 7'h07;
  localparam logic [6:0] LCD_REG_ON       = 7'h08;

  // Returns {addr[6:0], data[7:0]}
  function automatic logic [14:0] init_table(
    input logic [7:0] idx
  );
    logic [14:0] e;
    case (idx)
      8'd0:    e = {LCD_REG_POWER,    8'h80};
      8'd1:    e = {LCD_REG_DISP,     8'h01};
      8'd2:    e = {LCD_REG_CONTRAST, 8'h0F};
      8'd3:    e = {LCD_REG_BIAS,     8'h3C};
      8'd4:    e = {LCD_REG_SCROLL,   8'h00};
      8'd5:    e = {LCD_REG_CLEAR,    8'hFF};
      8'd6:    e = {LCD_REG_MODE,     8'h10};
      8'd7:    e = {LCD_REG_ON,       8'h55};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-port round-robin arbiter; the pointer names the
// port preferred on the next contended grant.
module lcd_rr_arbiter (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic en_i,
  output logic vld_o,
  output logic gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    vld_o = en_i && (req0_i || req1_i);
    gnt_o = (req0_i && req1_i) ? ptr_q : req1_i;
    ptr_d = vld_o ? ~gnt_o : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Shares one LCD transceiver between init table, host
// CPU and refresh engine, with a transfer timeout.
module lcd_bus_scheduler #(
  parameter int INIT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       i_clock,
  input  logic       i_resetN,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_rd0,
  input  logic       i_rd1,
  input  logic [6:0] i_addr0,
  input  logic [6:0] i_addr1,
  input  logic [7:0] i_wdata0,
  input  logic [7:0] i_wdata1,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic [7:0] o_rdata,
  output logic       o_error,
  output logic       o_initDone,
  output logic       o_txBegin,
  output logic       o_rxBegin,
  output logic [6:0] o_address,
  output logic [7:0] o_txData,
  input  logic       i_txBusy,
  input  logic       i_rxBusy,
  input  logic       i_txDone,
  input  logic       i_rxDone,
  input  logic [7:0] i_rxData
);
  import lcd_pkg::*;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] timer_q, timer_d;
  logic        rd_q, rd_d;
  logic        init_q, init_d;
  logic        gnt_q, gnt_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;

  logic arb_en, arb_vld, arb_gnt;
  logic busy, done, timing;

  lcd_rr_arbiter u_arb (
    .clk_i  (i_clock),
    .rst_ni (i_resetN),
    .req0_i (i_req0),
    .req1_i (i_req1),
    .en_i   (arb_en),
    .vld_o  (arb_vld),
    .gnt_o  (arb_gnt)
  );

  assign busy   = i_txBusy | i_rxBusy;
  assign done   = i_txDone | i_rxDone;
  assign timing = state_q inside
    {S_ISSUE, S_WAIT_DONE, S_WAIT_IDLE};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    rd_d    = rd_q;
    init_d  = init_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    done_d  = done_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    arb_en  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        if (idx_q == 8'(INIT_LEN)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        // transceiver has no reset; let it drain first
        end else if (!busy && !done) begin
          init_d  = 1'b1;
          rd_d    = 1'b0;
          err_d   = 1'b0;
          timer_d = '0;
          {addr_d, wdata_d} = init_table(idx_q);
          state_d = S_ISSUE;
        end
      end
      S_IDLE: begin
        arb_en = done_q;
        if (arb_vld) begin
          gnt_d   = arb_gnt;
          init_d  = 1'b0;
          err_d   = 1'b0;
          timer_d = '0;
          rd_d    = arb_gnt ? i_rd1 : i_rd0;
          addr_d  = arb_gnt ? i_addr1 : i_addr0;
          wdata_d = arb_gnt ? i_wdata1 : i_wdata0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = timer_q + 16'd1;
        if (rd_q ? i_rxBusy : i_txBusy) begin
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        timer_d = timer_q + 16'd1;
        if (rd_q ? i_rxDone : i_txDone) begin
          if (rd_q) rdata_d = i_rxData;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        timer_d = timer_q + 16'd1;
        if (!busy && !done) state_d = S_COMPLETE;
      end
      S_COMPLETE: begin
        if (init_q) begin
          idx_d   = idx_q + 8'd1;
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
    if (timing && timer_q == TMO) begin
      err_d   = 1'b1;
      rdata_d = rdata_q;
      state_d = S_COMPLETE;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      timer_q <= '0;
      rd_q    <= 1'b0;
      init_q  <= 1'b0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      rd_q    <= rd_d;
      init_q  <= init_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_txBegin  = (state_q == S_ISSUE) && !rd_q;
  assign o_rxBegin  = (state_q == S_ISSUE) && rd_q;
  assign o_ack0     = (state_q == S_COMPLETE) && !init_q && !gnt_q;
  assign o_ack1     = (state_q == S_COMPLETE) && !init_q && gnt_q;
  assign o_error    = (state_q == S_COMPLETE) && !init_q && err_q;
  assign o_rdata    = rdata_q;
  assign o_address  = addr_q;
  assign o_txData   = wdata_q;
  assign o_initDone = done_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: transceiver model with
// scoreboarded transfers and acks.
module tb_lcd_bus_scheduler;

  localparam int TO = 64;

  typedef struct {
    logic       rd;
    logic [6:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    logic       port;
    logic       rd;
    logic       err;
    logic [7:0] rdata;
  } ack_t;

  typedef struct {
    logic       port;
    logic       rd;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rx;
    int         lat;
    int         dur;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic req0, req1, rd0, rd1;
  logic [6:0] addr0, addr1;
  logic [7:0] wd0, wd1;
  logic ack0, ack1, err, idone, txb, rxb;
  logic [7:0] rdata, txd;
  logic [6:0] addr;

  logic m_txBusy = 1'b0, m_rxBusy = 1'b0;
  logic m_txDone = 1'b0, m_rxDone = 1'b0;
  logic [7:0] m_rxData = 8'h00;
  int   m_st = 0, m_cnt = 0;
  logic m_rd = 1'b0, m_hang = 1'b0;
  logic beg_prev = 1'b0;

  int   mod_lat = 1, mod_dur = 2;
  logic mod_hang = 1'b0;
  logic [7:0] mod_rx = 8'h00;

  txn_t txn_q[$];
  ack_t ack_q[$];
  int n_pass = 0, n_tot = 0;
  int cyc = 0, ack_cyc = 0, tbeg_low = 0;
  logic beg_seen = 1'b0, idone_prev = 1'b0;
  int exp_pend = 0;
  logic last_served = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_bus_scheduler #(
    .INIT_LEN(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk), .i_resetN(rstn),
    .i_req0(req0), .i_req1(req1),
    .i_rd0(rd0), .i_rd1(rd1),
    .i_addr0(addr0), .i_addr1(addr1),
    .i_wdata0(wd0), .i_wdata1(wd1),
    .o_ack0(ack0), .o_ack1(ack1),
    .o_rdata(rdata), .o_error(err),
    .o_initDone(idone),
    .o_txBegin(txb), .o_rxBegin(rxb),
    .o_address(addr), .o_txData(txd),
    .i_txBusy(m_txBusy), .i_rxBusy(m_rxBusy),
    .i_txDone(m_txDone), .i_rxDone(m_rxDone),
    .i_rxData(m_rxData)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  // behavioural transceiver
  always @(posedge clk) begin : model
    txn_t e;
    if (rstn && (txb || rxb) && !beg_prev)
      chk("begin_after_idle", m_st, 0);
    beg_prev <= txb || rxb;
    case (m_st)
      0: begin
        m_txDone <= 1'b0;
        m_rxDone <= 1'b0;
        if (txb || rxb) begin
          chk("begin_exclusive", 32'(txb && rxb), 0);
          if (txn_q.size() == 0) begin
            chk("unexpected_txn", 1, 0);
          end else begin
            e = txn_q.pop_front();
            chk("txn_rd", 32'(rxb), 32'(e.rd));
            chk("txn_addr", 32'(addr), 32'(e.addr));
            if (!e.rd) chk("txn_data", 32'(txd), 32'(e.data));
          end
          m_rd   <= rxb;
          m_hang <= mod_hang;
          m_cnt  <= mod_lat;
          m_st   <= 1;
        end
      end
      1: begin
        if (rstn)
          chk("begin_held", 32'(m_rd ? rxb : txb), 1);
        if (m_cnt == 0) begin
          if (m_rd) m_rxBusy <= 1'b1;
          else m_txBusy <= 1'b1;
          m_cnt <= mod_dur;
          m_st  <= 2;
        end else m_cnt <= m_cnt - 1;
      end
      2: begin
        if (m_hang) begin
          if (!mod_hang) begin
            m_txBusy <= 1'b0;
            m_rxBusy <= 1'b0;
            m_st     <= 0;
          end
        end else if (m_cnt == 0) begin
          m_txBusy <= 1'b0;
          m_rxBusy <= 1'b0;
          if (m_rd) m_rxDone <= 1'b1;
          else m_txDone <= 1'b1;
          m_rxData <= mod_rx;
          m_st     <= 3;
        end else m_cnt <= m_cnt - 1;
      end
      default: begin
        m_txDone <= 1'b0;
        m_rxDone <= 1'b0;
        m_st     <= 0;
      end
    endcase
  end

  always @(negedge clk) begin : mon
    ack_t a;
    if (rstn && (ack0 || ack1)) begin
      chk("ack_onehot", 32'(ack0 && ack1), 0);
      chk("ack_after_init", 32'(idone), 1);
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        a = ack_q.pop_front();
        chk("ack_port", 32'(ack1), 32'(a.port));
        chk("ack_error", 32'(err), 32'(a.err));
        if (a.rd && !a.err)
          chk("ack_rdata", 32'(rdata), 32'(a.rdata));
      end
      ack_cyc <= cyc;
    end
    if (beg_seen && !(txb || rxb)) tbeg_low <= cyc;
    beg_seen <= txb || rxb;
    if (rstn && idone && !idone_prev)
      chk("pending_held", ack_q.size(), exp_pend);
    idone_prev <= idone;
  end

  task automatic push_init();
    txn_q.push_back('{1'b0, 7'h01, 8'h80});
    txn_q.push_back('{1'b0, 7'h02, 8'h01});
    txn_q.push_back('{1'b0, 7'h03, 8'h0F});
    txn_q.push_back('{1'b0, 7'h04, 8'h3C});
    txn_q.push_back('{1'b0, 7'h05, 8'h00});
    txn_q.push_back('{1'b0, 7'h06, 8'hFF});
    txn_q.push_back('{1'b0, 7'h07, 8'h10});
    txn_q.push_back('{1'b0, 7'h08, 8'h55});
  endtask

  task automatic do_req(
    input logic p, input logic rd,
    input logic [6:0] a, input logic [7:0] d,
    input logic [7:0] rx, input logic [7:0] exp_rd,
    input logic e
  );
    bit got = 0;
    txn_q.push_back('{rd, a, d});
    ack_q.push_back('{p, rd, e, exp_rd});
    mod_rx = rx;
    if (!p) begin
      rd0 = rd; addr0 = a; wd0 = d; req0 = 1'b1;
    end else begin
      rd1 = rd; addr1 = a; wd1 = d; req1 = 1'b1;
    end
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (p ? ack1 : ack0) got = 1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    if (!got) chk("ack_timeout", 0, 1);
    last_served = p;
  endtask

  vec_t vt[6];

  initial begin : wdog
    #600000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    bit   s;
    int   n;
    logic p;
    vt[0] = '{0, 0, 7'h12, 8'hA5, 8'h00, 2, 3, 8'h00, 0};
    vt[1] = '{1, 1, 7'h20, 8'h00, 8'h3C, 1, 2, 8'h3C, 0};
    vt[2] = '{0, 1, 7'h7F, 8'h00, 8'h00, 0, 0, 8'h00, 0};
    vt[3] = '{1, 0, 7'h00, 8'hFF, 8'h00, 4, 5, 8'h00, 0};
    vt[4] = '{1, 1, 7'h55, 8'h00, 8'hC3, 1, 1, 8'hC3, 0};
    vt[5] = '{0, 1, 7'h01, 8'h00, 8'hFF, 3, 0, 8'hFF, 0};

    rstn = 1'b0;
    {req0, req1, rd0, rd1} = '0;
    {addr0, addr1, wd0, wd1} = '0;
    #12;
    chk("rst_txBegin", 32'(txb), 0);
    chk("rst_rxBegin", 32'(rxb), 0);
    chk("rst_ack", 32'({ack0, ack1}), 0);
    chk("rst_initDone", 32'(idone), 0);
    chk("rst_address", 32'(addr), 0);
    chk("rst_error", 32'(err), 0);

    // init table, with a request pending throughout it
    push_init();
    exp_pend = 1;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_req(0, 0, 7'h2A, 8'h5A, 8'h00, 8'h00, 0);
    chk("init_done", 32'(idone), 1);

    foreach (vt[i]) begin
      mod_lat = vt[i].lat;
      mod_dur = vt[i].dur;
      do_req(vt[i].port, vt[i].rd, vt[i].addr,
             vt[i].wdata, vt[i].rx,
             vt[i].exp_rdata, vt[i].exp_err);
    end

    // both held: grants must alternate
    mod_lat = 1;
    mod_dur = 1;
    s = !last_served;
    for (int k = 0; k < 6; k++) begin
      p = s ^ k[0];
      txn_q.push_back('{1'b0, p ? 7'h41 : 7'h40,
                       p ? 8'h0B : 8'h0A});
      ack_q.push_back('{p, 1'b0, 1'b0, 8'h00});
    end
    addr0 = 7'h40; wd0 = 8'h0A; rd0 = 1'b0;
    addr1 = 7'h41; wd1 = 8'h0B; rd1 = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 3000 && n < 6; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        n++;
        if (n == 6) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    chk("rr_six_acks", n, 6);
    last_served = !s;

    // done never comes: read times out
    mod_hang = 1'b1;
    do_req(0, 1, 7'h33, 8'h00, 8'hEE, 8'h00, 1);
    mod_hang = 1'b0;
    @(negedge clk);
    chk("timeout_latency", ack_cyc - tbeg_low, TO);
    chk("rdata_kept_on_timeout", 32'(rdata), 32'hFF);
    do_req(1, 1, 7'h34, 8'h00, 8'h99, 8'h99, 0);
    chk("rdata_after_recover", 32'(rdata), 32'h99);

    // reset in the middle of a read
    mod_lat = 1;
    mod_dur = 40;
    txn_q.push_back('{1'b1, 7'h60, 8'h00});
    rd1 = 1'b1; addr1 = 7'h60; wd1 = 8'h00;
    req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && m_st != 2; i++)
      @(negedge clk);
    chk("reset_test_reached_busy", m_st, 2);
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_txBegin", 32'(txb), 0);
    chk("arst_rxBegin", 32'(rxb), 0);
    chk("arst_address", 32'(addr), 0);
    chk("arst_rdata", 32'(rdata), 0);
    chk("arst_initDone", 32'(idone), 0);
    req1 = 1'b0;
    ack_q.delete();
    push_init();
    exp_pend = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3000 && !idone; i++)
      @(negedge clk);
    chk("reinit_done", 32'(idone), 1);

    repeat (5) @(negedge clk);
    chk("txn_queue_empty", txn_q.size(), 0);
    chk("ack_queue_empty", ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
